riscv_single_top: RTL and testbench

//  Single-cycle RV32I subset CPU top: controller + datapath (dp) + instruction memory + data memory.

---
 rtl/riscv_single_pkg.sv | 60 ++++++
 rtl/riscv_single_controller.sv | 72 +++++++
 rtl/riscv_single_datapath.sv | 66 ++++++
 rtl/riscv_single_mem.sv | 31 +++
 rtl/riscv_single_regfile.sv | 25 ++
 rtl/riscv_single_top.sv | 85 ++++++++
 tb/tb_riscv_single_top.sv | 311 +++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/riscv_single_pkg.sv
// Shared encodings and small combinational helpers for the single-cycle RV32I subset core.
package riscv_single_pkg;

    typedef enum logic [1:0] {
        ImmI = 2'b00,
        ImmS = 2'b01,
        ImmB = 2'b10,
        ImmJ = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        AluAdd = 2'b00,
        AluSub = 2'b01,
        AluAnd = 2'b10,
        AluOr  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ResAlu = 2'b00,
        ResMem = 2'b01,
        ResPc4 = 2'b10
    } res_src_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;

    // Sign-extended immediate; B/J formats carry an implicit zero LSB.
    function automatic logic [31:0] imm_ext(input logic [31:7] ins, input imm_src_e sel);
        logic [31:0] imm;
        imm = {{20{ins[31]}}, ins[31:20]};
        case (sel)
            ImmS:    imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            ImmB:    imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            ImmJ:    imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = {{20{ins[31]}}, ins[31:20]};
        endcase
        return imm;
    endfunction

    function automatic logic [31:0] alu_eval(input logic [31:0] a, input logic [31:0] b,
                                             input alu_op_e op);
        logic [31:0] y;
        case (op)
            AluSub:  y = a - b;
            AluAnd:  y = a & b;
            AluOr:   y = a | b;
            default: y = a + b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/riscv_single_controller.sv
// Main decoder: opcode/funct fields to datapath control; unknown opcodes decode as a nop.
module riscv_single_controller
    import riscv_single_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    output logic       reg_we_o,
    output logic       mem_we_o,
    output imm_src_e   imm_src_o,
    output alu_op_e    alu_ctrl_o,
    output logic       alu_src_o,
    output res_src_e   res_src_o,
    output logic       pc_src_o
);

    // Decode control from the current instruction fields and the ALU zero flag.
    always_comb begin
        reg_we_o   = 1'b0;
        mem_we_o   = 1'b0;
        imm_src_o  = ImmI;
        alu_ctrl_o = AluAdd;
        alu_src_o  = 1'b0;
        res_src_o  = ResAlu;
        pc_src_o   = 1'b0;
        case (op_i)
            OpLoad: begin
                reg_we_o  = 1'b1;
                alu_src_o = 1'b1;
                res_src_o = ResMem;
            end
            OpStore: begin
                mem_we_o  = 1'b1;
                imm_src_o = ImmS;
                alu_src_o = 1'b1;
            end
            OpReg: begin
                reg_we_o = 1'b1;
                case (funct3_i)
                    F3AddSub: alu_ctrl_o = funct7b5_i ? AluSub : AluAdd;
                    F3And:    alu_ctrl_o = AluAnd;
                    F3Or:     alu_ctrl_o = AluOr;
                    default:  alu_ctrl_o = AluAdd;
                endcase
            end
            OpImm: begin
                reg_we_o  = 1'b1;
                alu_src_o = 1'b1;
                // funct7 bit 5 is immediate payload here, so never select subtract
                case (funct3_i)
                    F3And:   alu_ctrl_o = AluAnd;
                    F3Or:    alu_ctrl_o = AluOr;
                    default: alu_ctrl_o = AluAdd;
                endcase
            end
            OpBranch: begin
                imm_src_o  = ImmB;
                alu_ctrl_o = AluSub;
                pc_src_o   = zero_i;
            end
            OpJal: begin
                reg_we_o  = 1'b1;
                imm_src_o = ImmJ;
                res_src_o = ResPc4;
                pc_src_o  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_single_datapath.sv
// Datapath: pc register, register file, immediate extender, ALU and writeback mux.
module riscv_single_datapath
    import riscv_single_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic        reg_we_i,
    input  imm_src_e    imm_src_i,
    input  alu_op_e     alu_ctrl_i,
    input  logic        alu_src_i,
    input  res_src_e    res_src_i,
    input  logic        pc_src_i,
    input  logic [31:0] mem_rd_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] alu_out_o,
    output logic [31:0] mem_wd_data_o,
    output logic        zero_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4, imm, src_a, rs2_data, src_b, result;
    logic        unused_opcode;

    assign unused_opcode = ^instr_i[6:0];

    // Register writes are held off while reset is asserted.
    riscv_single_regfile rf (
        .clk   (clk),
        .we3   (reg_we_i & rst),
        .addr1 (instr_i[19:15]),
        .addr2 (instr_i[24:20]),
        .addr3 (instr_i[11:7]),
        .wd3   (result),
        .rd1   (src_a),
        .rd2   (rs2_data)
    );

    assign imm           = imm_ext(instr_i[31:7], imm_src_i);
    assign src_b         = alu_src_i ? imm : rs2_data;
    assign alu_out_o     = alu_eval(src_a, src_b, alu_ctrl_i);
    assign zero_o        = (alu_out_o == 32'd0);
    assign mem_wd_data_o = rs2_data;
    assign pc_plus4      = pc_q + 32'd4;
    assign pc_o          = pc_q;

    // Writeback source and next pc selection.
    always_comb begin
        case (res_src_i)
            ResMem:  result = mem_rd_data_i;
            ResPc4:  result = pc_plus4;
            default: result = alu_out_o;
        endcase
        pc_d = pc_src_i ? (pc_q + imm) : pc_plus4;
    end

    // Program counter with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/riscv_single_mem.sv
// Word-addressed RAM, async read, sync write. Byte address bits [1:0] are ignored and the word
// index wraps modulo Words (Words must be a power of two).
module riscv_single_mem #(
    parameter int unsigned Words = 64
) (
    input  logic        clk,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd_o
);

    localparam int unsigned Aw = $clog2(Words);

    logic [31:0]   _mem [0:Words-1];
    logic [Aw-1:0] idx;
    logic          unused_addr;

    assign idx         = addr_i[2 +: Aw];
    assign unused_addr = ^{addr_i[31:Aw+2], addr_i[1:0]};

    // Store one word per write-enabled edge; contents are not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            _mem[idx] <= wd_i;
        end
    end

    assign rd_o = _mem[idx];

endmodule

// File: rtl/riscv_single_regfile.sv
// 32 x 32-bit register file: two async read ports, one sync write port, x0 hardwired to zero.
module riscv_single_regfile (
    input  logic        clk,
    input  logic        we3,
    input  logic [4:0]  addr1,
    input  logic [4:0]  addr2,
    input  logic [4:0]  addr3,
    input  logic [31:0] wd3,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] _reg [0:31];

    // Contents are deliberately not reset; writes to x0 are dropped.
    always_ff @(posedge clk) begin
        if (we3 && (addr3 != 5'd0)) begin
            _reg[addr3] <= wd3;
        end
    end

    assign rd1 = (addr1 == 5'd0) ? '0 : _reg[addr1];
    assign rd2 = (addr2 == 5'd0) ? '0 : _reg[addr2];

endmodule

// File: rtl/riscv_single_top.sv
// Single-cycle RV32I subset CPU: controller, datapath and instruction/data memories.
module riscv_single_top
    import riscv_single_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned DMEM_WORDS = 64
) (
    output logic        reg_we,
    output logic        mem_we,
    output logic [1:0]  imm_src,
    output logic [1:0]  alu_ctrl,
    output logic        alu_src,
    output logic [1:0]  res_src,
    output logic        pc_src,
    output logic [31:0] instr,
    output logic [31:0] alu_out,
    output logic [31:0] mem_rd_data,
    output logic [31:0] mem_wd_data,
    output logic [31:0] pc,
    input  logic        rst,
    input  logic        clk
);

    imm_src_e imm_src_w;
    alu_op_e  alu_ctrl_w;
    res_src_e res_src_w;
    logic     zero;

    assign imm_src  = imm_src_w;
    assign alu_ctrl = alu_ctrl_w;
    assign res_src  = res_src_w;

    riscv_single_controller ctrl (
        .op_i       (instr[6:0]),
        .funct3_i   (instr[14:12]),
        .funct7b5_i (instr[30]),
        .zero_i     (zero),
        .reg_we_o   (reg_we),
        .mem_we_o   (mem_we),
        .imm_src_o  (imm_src_w),
        .alu_ctrl_o (alu_ctrl_w),
        .alu_src_o  (alu_src),
        .res_src_o  (res_src_w),
        .pc_src_o   (pc_src)
    );

    riscv_single_datapath dp (
        .clk           (clk),
        .rst           (rst),
        .instr_i       (instr),
        .reg_we_i      (reg_we),
        .imm_src_i     (imm_src_w),
        .alu_ctrl_i    (alu_ctrl_w),
        .alu_src_i     (alu_src),
        .res_src_i     (res_src_w),
        .pc_src_i      (pc_src),
        .mem_rd_data_i (mem_rd_data),
        .pc_o          (pc),
        .alu_out_o     (alu_out),
        .mem_wd_data_o (mem_wd_data),
        .zero_o        (zero)
    );

    riscv_single_mem #(
        .Words (IMEM_WORDS)
    ) instr_mem (
        .clk    (clk),
        .we_i   (1'b0),
        .addr_i (pc),
        .wd_i   ('0),
        .rd_o   (instr)
    );

    // Stores are held off while reset is asserted.
    riscv_single_mem #(
        .Words (DMEM_WORDS)
    ) data_mem (
        .clk    (clk),
        .we_i   (mem_we & rst),
        .addr_i (alu_out),
        .wd_i   (mem_wd_data),
        .rd_o   (mem_rd_data)
    );

endmodule

// File: tb/tb_riscv_single_top.sv
// Scoreboard bench: expectations are queued with the edge count at which they become due.
module tb_riscv_single_top;

    logic        clk, rst;
    logic        reg_we, mem_we, alu_src, pc_src;
    logic [1:0]  imm_src, alu_ctrl, res_src;
    logic [31:0] instr, alu_out, mem_rd_data, mem_wd_data, pc;

    int total = 0;
    int bad   = 0;

    localparam int KPc = 0, KAlu = 1, KRd = 2, KWd = 3, KInstr = 4, KCtl = 5, KWe = 6;
    localparam int KReg = 7, KMem = 8;
    localparam logic [31:0] MAll = 32'hffff_ffff, MNoRes = 32'h3f9, MNoImm = 32'h33f;
    localparam logic [31:0] MJal = 32'h3c7;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] exp;
        logic [31:0] mask;
        int          at;
    } exp_t;

    exp_t sb[$];

    riscv_single_top dut (
        .reg_we      (reg_we),
        .mem_we      (mem_we),
        .imm_src     (imm_src),
        .alu_ctrl    (alu_ctrl),
        .alu_src     (alu_src),
        .res_src     (res_src),
        .pc_src      (pc_src),
        .instr       (instr),
        .alu_out     (alu_out),
        .mem_rd_data (mem_rd_data),
        .mem_wd_data (mem_wd_data),
        .pc          (pc),
        .rst         (rst),
        .clk         (clk)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    // Instruction encoders (independent of the RTL decoder).
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] ctl(input logic rw, input logic mw, input logic [1:0] imm,
                                        input logic [1:0] alu, input logic asrc,
                                        input logic [1:0] res, input logic pcs);
        return {22'd0, rw, mw, imm, alu, asrc, res, pcs};
    endfunction

    function automatic logic [31:0] observe(input int kind, input int idx);
        case (kind)
            KPc:     return pc;
            KAlu:    return alu_out;
            KRd:     return mem_rd_data;
            KWd:     return mem_wd_data;
            KInstr:  return instr;
            KCtl:    return {22'd0, reg_we, mem_we, imm_src, alu_ctrl, alu_src, res_src, pc_src};
            KWe:     return {29'd0, reg_we, mem_we, pc_src};
            KReg:    return dut.dp.rf._reg[idx];
            KMem:    return dut.data_mem._mem[idx];
            default: return 'x;
        endcase
    endfunction

    task automatic push(input string name, input int kind, input int idx,
                        input logic [31:0] exp, input logic [31:0] mask, input int at);
        sb.push_back('{name, kind, idx, exp, mask, at});
    endtask

    task automatic clear_state();
        for (int i = 0; i < 32; i++) dut.dp.rf._reg[i] = '0;
        for (int i = 0; i < 64; i++) begin
            dut.instr_mem._mem[i] = '0;
            dut.data_mem._mem[i]  = '0;
        end
        dut.dp.rf._reg[9]    = 32'd8;
        dut.dp.rf._reg[5]    = 32'hffff_fffe;
        dut.data_mem._mem[1] = 32'hdead_c0de;
    endtask

    // One pass of the lw/sw/or/beq loop starting at pc 0.
    task automatic push_main_loop(input string tag);
        push({tag, "_pc0"},    KPc,    0, 32'd0,         MAll, 0);
        push({tag, "_instr0"}, KInstr, 0, 32'hffc4_a303, MAll, 0);
        push({tag, "_ctl_lw"}, KCtl,   0, ctl(1, 0, 2'b00, 2'b00, 1, 2'b01, 0), MAll, 0);
        push({tag, "_alu_lw"}, KAlu,   0, 32'd4,         MAll, 0);
        push({tag, "_rd_lw"},  KRd,    0, 32'hdead_c0de, MAll, 0);
        push({tag, "_pc1"},    KPc,    0, 32'd4,         MAll, 1);
        push({tag, "_x6"},     KReg,   6, 32'hdead_c0de, MAll, 1);
        push({tag, "_ctl_sw"}, KCtl,   0, ctl(0, 1, 2'b01, 2'b00, 1, 2'b00, 0), MNoRes, 1);
        push({tag, "_alu_sw"}, KAlu,   0, 32'd16,        MAll, 1);
        push({tag, "_wd_sw"},  KWd,    0, 32'hdead_c0de, MAll, 1);
        push({tag, "_pc2"},    KPc,    0, 32'd8,         MAll, 2);
        push({tag, "_dmem4"},  KMem,   4, 32'hdead_c0de, MAll, 2);
        push({tag, "_ctl_or"}, KCtl,   0, ctl(1, 0, 2'b00, 2'b11, 0, 2'b00, 0), MNoImm, 2);
        push({tag, "_alu_or"}, KAlu,   0, 32'hffff_fffe, MAll, 2);
        push({tag, "_pc3"},    KPc,    0, 32'd12,        MAll, 3);
        push({tag, "_x4"},     KReg,   4, 32'hffff_fffe, MAll, 3);
        push({tag, "_ctl_beq"}, KCtl,  0, ctl(0, 0, 2'b10, 2'b01, 0, 2'b00, 1), MNoRes, 3);
        push({tag, "_alu_beq"}, KAlu,  0, 32'd0,         MAll, 3);
        push({tag, "_pc4"},    KPc,    0, 32'd0,         MAll, 4);
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] act;
        clear_state();
        dut.instr_mem._mem[0] = 32'hffc4_a303;
        dut.instr_mem._mem[1] = 32'h0064_a423;
        dut.instr_mem._mem[2] = 32'h0062_e233;
        dut.instr_mem._mem[3] = 32'hfe42_0ae3;
        #5;
        push("rst_pc",  KPc,  0, 32'd0, MAll, 0);
        push("rst_alu", KAlu, 0, 32'd4, MAll, 0);
        for (int c = 0; c <= 0; c++) begin
            while (sb.size() > 0 && sb[0].at == c) begin
                e = sb.pop_front();
                act = observe(e.kind, e.idx);
                total++;
                if ((act & e.mask) !== (e.exp & e.mask)) begin
                    bad++;
                    $display("FAIL %s: actual=%h required=%h", e.name, act & e.mask,
                             e.exp & e.mask);
                end
            end
        end
    endtask

    task automatic test_program();
        exp_t e;
        logic [31:0] act;
        push_main_loop("loop1");
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) @(negedge clk);
            while (sb.size() > 0 && sb[0].at == c) begin
                e = sb.pop_front();
                act = observe(e.kind, e.idx);
                total++;
                if ((act & e.mask) !== (e.exp & e.mask)) begin
                    bad++;
                    $display("FAIL %s: actual=%h required=%h", e.name, act & e.mask,
                             e.exp & e.mask);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] act;
        // Wipe the loop's results so the second pass has to recreate them.
        dut.dp.rf._reg[4]    = '0;
        dut.dp.rf._reg[6]    = '0;
        dut.data_mem._mem[4] = '0;
        push_main_loop("loop2");
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) @(negedge clk);
            while (sb.size() > 0 && sb[0].at == c) begin
                e = sb.pop_front();
                act = observe(e.kind, e.idx);
                total++;
                if ((act & e.mask) !== (e.exp & e.mask)) begin
                    bad++;
                    $display("FAIL %s: actual=%h required=%h", e.name, act & e.mask,
                             e.exp & e.mask);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        logic [31:0] act;
        push("arst_pre_pc",  KPc,  0, 32'd4,  MAll, 1);
        push("arst_pc_now",  KPc,  0, 32'd0,  MAll, 2);
        push("arst_pc_held", KPc,  0, 32'd0,  MAll, 3);
        push("arst_x6_held", KReg, 6, 32'h55, MAll, 3);
        for (int c = 0; c <= 3; c++) begin
            if (c == 1) @(negedge clk);
            if (c == 2) begin
                rst = 1'b0;
                dut.dp.rf._reg[6] = 32'h55;
                #1;
            end
            if (c == 3) @(negedge clk);
            while (sb.size() > 0 && sb[0].at == c) begin
                e = sb.pop_front();
                act = observe(e.kind, e.idx);
                total++;
                if ((act & e.mask) !== (e.exp & e.mask)) begin
                    bad++;
                    $display("FAIL %s: actual=%h required=%h", e.name, act & e.mask,
                             e.exp & e.mask);
                end
            end
        end
    endtask

    task automatic test_ops();
        exp_t e;
        logic [31:0] act;
        clear_state();
        dut.dp.rf._reg[0]  = 32'h77;
        dut.dp.rf._reg[31] = 32'h1234;
        dut.instr_mem._mem[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011);
        dut.instr_mem._mem[1]  = enc_i(12'd3, 5'd0, 3'b000, 5'd7, 7'b0010011);
        dut.instr_mem._mem[2]  = 32'hffff_ffff;
        dut.instr_mem._mem[3]  = enc_i(12'h0f0, 5'd5, 3'b111, 5'd8, 7'b0010011);
        dut.instr_mem._mem[4]  = enc_r(7'b0100000, 5'd5, 5'd9, 3'b000, 5'd10);
        dut.instr_mem._mem[5]  = enc_r(7'b0000000, 5'd9, 5'd5, 3'b000, 5'd11);
        dut.instr_mem._mem[6]  = enc_r(7'b0000000, 5'd10, 5'd5, 3'b111, 5'd12);
        dut.instr_mem._mem[7]  = enc_i(12'hfff, 5'd0, 3'b110, 5'd13, 7'b0010011);
        dut.instr_mem._mem[8]  = enc_j(21'd8, 5'd1);
        dut.instr_mem._mem[9]  = enc_i(12'd1, 5'd0, 3'b000, 5'd14, 7'b0010011);
        dut.instr_mem._mem[10] = enc_b(13'd16, 5'd5, 5'd9);
        dut.instr_mem._mem[11] = enc_s(12'd3, 5'd13, 5'd9);
        dut.instr_mem._mem[12] = enc_i(12'd2, 5'd9, 3'b010, 5'd15, 7'b0000011);
        dut.instr_mem._mem[13] = enc_i(12'd252, 5'd9, 3'b010, 5'd16, 7'b0000011);
        @(negedge clk);
        rst = 1'b1;
        push("x0_pc",       KPc,  0,  32'd4,          MAll, 1);
        push("x0_unwritten", KReg, 0, 32'h77,         MAll, 1);
        push("x0_reads0",   KReg, 7,  32'd3,          MAll, 2);
        push("nop_ctl",     KWe,  0,  32'd0,          MAll, 2);
        push("nop_pc",      KPc,  0,  32'd12,         MAll, 3);
        push("nop_x31",     KReg, 31, 32'h1234,       MAll, 3);
        push("nop_dmem2",   KMem, 2,  32'd0,          MAll, 3);
        push("nop_dmem1",   KMem, 1,  32'hdead_c0de,  MAll, 3);
        push("andi_x8",     KReg, 8,  32'h0000_00f0,  MAll, 4);
        push("sub_x10",     KReg, 10, 32'd8 - 32'hffff_fffe, MAll, 5);
        push("add_wrap_x11", KReg, 11, 32'd6,         MAll, 6);
        push("and_x12",     KReg, 12, 32'h0000_000a,  MAll, 7);
        push("ori_x13",     KReg, 13, 32'hffff_ffff,  MAll, 8);
        push("jal_ctl",     KCtl, 0,  ctl(1, 0, 2'b11, 2'b00, 0, 2'b10, 1), MJal, 8);
        push("jal_pc",      KPc,  0,  32'd40,         MAll, 9);
        push("jal_link_x1", KReg, 1,  32'd36,         MAll, 9);
        push("beq_nt_pc",   KPc,  0,  32'd44,         MAll, 10);
        push("jal_skip_x14", KReg, 14, 32'd0,         MAll, 10);
        push("sw_misalign", KMem, 2,  32'hffff_ffff,  MAll, 11);
        push("sw_pc",       KPc,  0,  32'd48,         MAll, 11);
        push("lw_misalign", KReg, 15, 32'hffff_ffff,  MAll, 12);
        push("lw_wrap_x16", KReg, 16, 32'hdead_c0de,  MAll, 13);
        push("end_pc",      KPc,  0,  32'd56,         MAll, 13);
        for (int c = 0; c <= 13; c++) begin
            if (c > 0) @(negedge clk);
            while (sb.size() > 0 && sb[0].at == c) begin
                e = sb.pop_front();
                act = observe(e.kind, e.idx);
                total++;
                if ((act & e.mask) !== (e.exp & e.mask)) begin
                    bad++;
                    $display("FAIL %s: actual=%h required=%h", e.name, act & e.mask,
                             e.exp & e.mask);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        test_program();
        test_back_to_back();
        test_async_reset();
        test_ops();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
